// File: rtl/b01_pkg.sv
// Shared types and constants for the multi-channel serial adder.
package b01_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned OVF_UNSIGNED = 0;
    localparam int unsigned OVF_SIGNED   = 1;
    localparam int unsigned OVF_CNT_W    = 8;

endpackage : b01_pkg

// File: rtl/b01_serial_add_slice.sv
// One channel of the serial adder: carry flop plus registered sum and overflow.
module b01_serial_add_slice
    import b01_pkg::*;
#(
    parameter int unsigned SIGNED_MODE = OVF_UNSIGNED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    input  logic first,
    input  logic last,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic ovf
);

    logic carry_q;
    logic cin_c;
    logic s_c;
    logic cout_c;

    // Full adder; bit 0 of a word always starts with a clear carry.
    always_comb begin
        cin_c  = first ? 1'b0 : carry_q;
        s_c    = a ^ b ^ cin_c;
        cout_c = (a & b) | (a & cin_c) | (b & cin_c);
    end

    // Carry, sum and overflow registers; overflow only moves on the MSB beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            sum     <= 1'b0;
            ovf     <= 1'b0;
        end else if (consume) begin
            carry_q <= last ? 1'b0 : cout_c;
            sum     <= s_c;
            if (last) begin
                ovf <= (SIGNED_MODE == OVF_SIGNED) ? (cin_c ^ cout_c) : cout_c;
            end
        end
    end

endmodule : b01_serial_add_slice

// File: rtl/b01_serial_adder_mc.sv
// Multi-channel word-framed serial adder with overflow detection.
// Optional per-channel overflow counters: define B01_OVF_COUNT_EN.
module b01_serial_adder_mc
    import b01_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned WORD_LEN    = 8,
    parameter int unsigned SIGNED_MODE = OVF_UNSIGNED
) (
    input  logic                        clock,
    input  logic                        nRESET_G,
    input  logic                        START,
    input  logic                        VALID,
    input  logic [N_CH-1:0]             LINE1,
    input  logic [N_CH-1:0]             LINE2,
`ifdef B01_OVF_COUNT_EN
    input  logic                        CLR_CNT,
    output logic [N_CH*OVF_CNT_W-1:0]   OVF_CNT,
`endif
    output logic [N_CH-1:0]             OUTP_REG,
    output logic                        OUT_VALID,
    output logic [N_CH-1:0]             OVERFLW_REG,
    output logic                        WORD_DONE,
    output logic                        BUSY
);

    localparam int unsigned CNT_W = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WORD_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             consume_c;
    logic             first_c;
    logic             last_c;

    // State register, bit counter and shared output pulses.
    always_ff @(posedge clock or negedge nRESET_G) begin
        if (!nRESET_G) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            OUT_VALID <= 1'b0;
            WORD_DONE <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            OUT_VALID <= consume_c;
            WORD_DONE <= last_c;
            BUSY      <= (state_d == RUN);
        end
    end

    // Next state and beat qualifiers; START on the MSB beat is ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        consume_c = 1'b0;
        first_c   = 1'b0;
        last_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (VALID && START) begin
                    consume_c = 1'b1;
                    first_c   = 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (VALID) begin
                    consume_c = 1'b1;
                    if (cnt_q == MSB_IDX) begin
                        last_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (START) begin
                        first_c = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_slice
        b01_serial_add_slice #(
            .SIGNED_MODE (SIGNED_MODE)
        ) u_slice (
            .clk     (clock),
            .rst_n   (nRESET_G),
            .consume (consume_c),
            .first   (first_c),
            .last    (last_c),
            .a       (LINE1[i]),
            .b       (LINE2[i]),
            .sum     (OUTP_REG[i]),
            .ovf     (OVERFLW_REG[i])
        );
    end

`ifdef B01_OVF_COUNT_EN
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ovf_cnt
        logic [OVF_CNT_W-1:0] ovf_cnt_q;

        // Saturating count of overflowing words; clear wins over increment.
        always_ff @(posedge clock or negedge nRESET_G) begin
            if (!nRESET_G) begin
                ovf_cnt_q <= '0;
            end else if (CLR_CNT) begin
                ovf_cnt_q <= '0;
            end else if (WORD_DONE && OVERFLW_REG[i] && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
            end
        end

        assign OVF_CNT[i*OVF_CNT_W +: OVF_CNT_W] = ovf_cnt_q;
    end
`endif

endmodule : b01_serial_adder_mc
